// File: rtl/mem_arbiter.sv
// mem_arbiter: req/ack arbiter sharing one single-port memory (clk, reset, req/rw/addr/wdata/ack/rdata x2, mem_valid/rw/addr/din/dout, busy); define MEM_ARB_FIXED_PRIO_EN for fixed priority instead of round robin
module mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nxt;
  logic eff0, eff1, grant, id;
  assign eff0 = req0 & ~ack0;
  assign eff1 = req1 & ~ack1;
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign grant = ~eff0;
`else
  logic last_grant;
  assign grant = (eff0 & eff1) ? ~last_grant : eff1;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_grant <= 1'b1;
    else if (state == IDLE && (eff0 | eff1)) last_grant <= grant;
`endif
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state == IDLE ? ((eff0 | eff1) ? ISSUE : IDLE) : state == ISSUE ? RESP : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      id        <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      state     <= state_nxt;
      mem_valid <= state_nxt == ISSUE;
      ack0      <= state == RESP && !id;
      ack1      <= state == RESP && id;
      if (state == IDLE && (eff0 | eff1)) begin
        id       <= grant;
        mem_rw   <= grant ? rw1 : rw0;
        mem_addr <= grant ? addr1 : addr0;
        mem_din  <= grant ? wdata1 : wdata0;
      end
      if (state == RESP && mem_rw && !id) rdata0 <= mem_dout;
      if (state == RESP && mem_rw && id) rdata1 <= mem_dout;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory and reference memory model
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, mem_valid, mem_rw, busy;
  logic [31:0] rdata0, rdata1, mem_din, mem_dout;
  logic [7:0]  mem_addr;
  always #5 clk = ~clk;
  mem_arbiter #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );
  logic [31:0] mem_arr [256];
  always @(posedge clk or posedge reset)
    if (reset) begin
      mem_dout <= '0;
      for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
    end else if (mem_valid) begin
      if (mem_rw) mem_dout <= mem_arr[mem_addr];
      else mem_arr[mem_addr] <= mem_din;
    end
  int vectors = 0, errors = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] hold [2];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int ack_log [$];
  int lat_r [2];
  int oth_r [2];
  logic [2:0] vtr_r [2];
  logic [2:0] btr_r [2];
  logic [7:0] fa_r [2];
  logic frw_r [2];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ack0"}, 64'(ack0), 64'd0);
    chk({tag, "_ack1"}, 64'(ack1), 64'd0);
    chk({tag, "_rdata0"}, 64'(rdata0), 64'd0);
    chk({tag, "_rdata1"}, 64'(rdata1), 64'd0);
    chk({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, "_mem_rw"}, 64'(mem_rw), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_din"}, 64'(mem_din), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    hold[0] = '0;
    hold[1] = '0;
    exp_q0.delete();
    exp_q1.delete();
  endtask
  logic pa0 = 1'b0, pa1 = 1'b0;
  always @(negedge clk)
    if (reset) begin
      pa0 = 1'b0;
      pa1 = 1'b0;
    end else begin
      if (ack0) begin
        ack_log.push_back(0);
        chk("ack0_pulse_width", 64'(pa0), 64'd0);
        if (exp_q0.size() == 0) chk("ack0_unexpected", 64'(exp_q0.size()), 64'd1);
        else chk("rdata0", 64'(rdata0), 64'(exp_q0.pop_front()));
      end
      if (ack1) begin
        ack_log.push_back(1);
        chk("ack1_pulse_width", 64'(pa1), 64'd0);
        if (exp_q1.size() == 0) chk("ack1_unexpected", 64'(exp_q1.size()), 64'd1);
        else chk("rdata1", 64'(rdata1), 64'(exp_q1.pop_front()));
      end
      pa0 = ack0;
      pa1 = ack1;
    end
  task automatic txn(input int p, input logic rw, input logic [7:0] a, input logic [31:0] d);
    logic [31:0] e;
    logic acked;
    if (rw) begin
      e = ref_mem[a];
      hold[p] = e;
    end else begin
      ref_mem[a] = d;
      e = hold[p];
    end
    if (p == 0) begin
      exp_q0.push_back(e);
      rw0 = rw; addr0 = a; wdata0 = d; req0 = 1'b1;
    end else begin
      exp_q1.push_back(e);
      rw1 = rw; addr1 = a; wdata1 = d; req1 = 1'b1;
    end
    lat_r[p] = 0; oth_r[p] = 0; vtr_r[p] = '0; btr_r[p] = '0; fa_r[p] = '0; frw_r[p] = 1'b0;
    acked = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      lat_r[p] = i;
      if (i <= 3) begin
        vtr_r[p][i-1] = mem_valid;
        btr_r[p][i-1] = busy;
      end
      if (i == 1) begin
        fa_r[p] = mem_addr;
        frw_r[p] = mem_rw;
      end
      if (p == 0 ? ack1 : ack0) oth_r[p]++;
      if (p == 0 ? ack0 : ack1) begin
        acked = 1'b1;
        break;
      end
    end
    chk($sformatf("ack%0d_timeout", p), 64'(acked), 64'd1);
    @(posedge clk);
    #1;
    if (p == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_zero("reset");
    txn(0, 1'b0, 8'h05, 32'hDEADBEEF);
    chk("t1_latency", 64'(lat_r[0]), 64'd3);
    chk("t1_mem_valid_trace", 64'(vtr_r[0]), 64'b001);
    chk("t1_busy_trace", 64'(btr_r[0]), 64'b011);
    chk("t1_mem_addr", 64'(fa_r[0]), 64'h05);
    chk("t1_mem_rw", 64'(frw_r[0]), 64'd0);
    txn(1, 1'b1, 8'h05, 32'h0);
    chk("t2_latency", 64'(lat_r[1]), 64'd3);
    chk("t2_rdata1", 64'(rdata1), 64'hDEADBEEF);
    chk("t2_rdata0_held", 64'(rdata0), 64'd0);
    ack_log.delete();
    fork
      txn(0, 1'b0, 8'h20, 32'h11111111);
      txn(1, 1'b0, 8'h21, 32'h22222222);
    join
    chk("t3a_first", 64'(ack_log[0]), 64'd0);
    chk("t3a_second", 64'(ack_log[1]), 64'd1);
    chk("t3a_lat0", 64'(lat_r[0]), 64'd3);
    chk("t3a_lat1", 64'(lat_r[1]), 64'd6);
    txn(0, 1'b1, 8'h20, 32'h0);
    ack_log.delete();
    fork
      txn(0, 1'b1, 8'h21, 32'h0);
      txn(1, 1'b1, 8'h20, 32'h0);
    join
`ifdef MEM_ARB_FIXED_PRIO_EN
    chk("t3b_first", 64'(ack_log[0]), 64'd0);
    chk("t3b_second", 64'(ack_log[1]), 64'd1);
`else
    chk("t3b_first", 64'(ack_log[0]), 64'd1);
    chk("t3b_second", 64'(ack_log[1]), 64'd0);
    chk("t3b_lat1", 64'(lat_r[1]), 64'd3);
    chk("t3b_lat0", 64'(lat_r[0]), 64'd6);
`endif
    txn(1, 1'b1, 8'h05, 32'h0);
    ack_log.delete();
    fork
      for (int k = 0; k < 2; k++) begin
        txn(0, 1'(k), 8'h30, 32'hA0A0A0A0);
        @(posedge clk);
        #1;
      end
      for (int k = 0; k < 2; k++) begin
        txn(1, 1'(k), 8'h31, 32'hB0B0B0B0);
        @(posedge clk);
        #1;
      end
    join
    chk("t4_count", 64'(ack_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("t4_order%0d", k), 64'(ack_log[k]), 64'(k % 2));
    txn(0, 1'b0, 8'h10, 32'h12345678);
    rw0 = 1'b1; addr0 = 8'h10; wdata0 = 32'hA5A5A5A5; req0 = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_in_issue", 64'({busy, mem_valid}), 64'b11);
    reset = 1'b1;
    #1;
    chk_zero("t5_reset");
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_ack", 64'({ack0, ack1}), 64'd0);
    txn(0, 1'b1, 8'h10, 32'h0);
    chk("t5_reread", 64'(rdata0), 64'd0);
    txn(1, 1'b0, 8'hFF, 32'hFFFFFFFF);
    txn(1, 1'b1, 8'hFF, 32'h0);
    chk("t6_rdata1", 64'(rdata1), 64'hFFFFFFFF);
    txn(0, 1'b1, 8'h00, 32'h0);
    chk("t6_addr0", 64'(rdata0), 64'd0);
    fork
      for (int k = 0; k < 30; k++) begin
        txn(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), $urandom);
`ifndef MEM_ARB_FIXED_PRIO_EN
        chk("rand_wait0", 64'(oth_r[0] <= 1), 64'd1);
`endif
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      for (int k = 0; k < 30; k++) begin
        txn(1, 1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)), $urandom);
`ifndef MEM_ARB_FIXED_PRIO_EN
        chk("rand_wait1", 64'(oth_r[1] <= 1), 64'd1);
`endif
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("q0_drained", 64'(exp_q0.size()), 64'd0);
    chk("q1_drained", 64'(exp_q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
